// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths, frame constants and FSM encoding for spi_controller
package spi_pkg;

  localparam int ASZ_DEF    = 7;
  localparam int DSZ_DEF    = 32;
  localparam int DIV_DEF    = 4;
  localparam int CS_GAP_DEF = 8;

  localparam int FRAME_LEN  = 1 + ASZ_DEF + DSZ_DEF;
  // first rising edge whose CIPO sample is real read data
  localparam int RX_FIRST   = ASZ_DEF + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period tick generator, one tick every DIV clk cycles
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - CPOL0/CPHA0 SPI initiator for {rw, addr, data} frames
// Optional inter-frame chip-select gap: SPI_CTRL_CS_GAP_EN.
module spi_controller
  import spi_pkg::*;
#(
  parameter int ASZ = ASZ_DEF,
  parameter int DSZ = DSZ_DEF,
  parameter int DIV = DIV_DEF
`ifdef SPI_CTRL_CS_GAP_EN
  , parameter int CS_GAP = CS_GAP_DEF
`endif
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           rw,
  input  logic [ASZ-1:0] addr,
  input  logic [DSZ-1:0] wdat,
  output logic           busy,
  output logic           done,
  output logic [DSZ-1:0] rdat,
  output logic           spi_clk,
  output logic           spi_cs,
  output logic           spi_copi,
  input  logic           spi_cipo
);

  localparam int FLEN = 1 + ASZ + DSZ;
  localparam int NW   = $clog2(FLEN + 1);
  localparam logic [NW-1:0] N_LAST = NW'(FLEN);

`ifdef SPI_CTRL_CS_GAP_EN
  // GAP lasts CS_GAP-1 cycles so a start issued as soon as busy drops sees CS_GAP high cycles
  localparam int GW = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(CS_GAP - 2);
  localparam state_t END_STATE = GAP;
  localparam logic BUSY_HOLD = 1'b1;
  logic [GW-1:0] gcnt;
  logic          gap_exit;
`else
  localparam state_t END_STATE = IDLE;
  localparam logic BUSY_HOLD = 1'b0;
`endif

  state_t         state, state_nx;
  logic [FLEN-1:0] tx_sh;
  logic [DSZ-1:0]  rx_sh;
  logic [NW-1:0]   n;
  logic            rw_q;
  logic            tick;
  logic            accept, to_high, to_low, finish;

  spi_clk_div #(.DIV(DIV)) u_clk_div (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (state == IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    to_high  = 1'b0;
    to_low   = 1'b0;
    finish   = 1'b0;
`ifdef SPI_CTRL_CS_GAP_EN
    gap_exit = 1'b0;
`endif
    unique case (state)
      IDLE:  if (start) begin accept = 1'b1; state_nx = SETUP; end
      SETUP: if (tick)  begin to_high = 1'b1; state_nx = HIGH; end
      HIGH:  if (tick)  begin to_low = 1'b1;  state_nx = LOW;  end
      LOW: begin
        if (tick) begin
          if (n != N_LAST) begin
            to_high  = 1'b1;
            state_nx = HIGH;
          end else begin
            finish   = 1'b1;
            state_nx = END_STATE;
          end
        end
      end
`ifdef SPI_CTRL_CS_GAP_EN
      GAP: if (gcnt == G_LAST) begin gap_exit = 1'b1; state_nx = IDLE; end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // CIPO is captured on the same edge that raises spi_clk; COPI advances on the falling one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_clk  <= 1'b0;
      spi_cs   <= 1'b1;
      spi_copi <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdat     <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      n        <= '0;
      rw_q     <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        tx_sh    <= {rw, addr, wdat};
        rw_q     <= rw;
        n        <= '0;
        spi_cs   <= 1'b0;
        spi_copi <= rw;
        busy     <= 1'b1;
      end
      if (to_high) begin
        spi_clk <= 1'b1;
        rx_sh   <= {rx_sh[DSZ-2:0], spi_cipo};
        n       <= n + 1'b1;
      end
      if (to_low) begin
        spi_clk  <= 1'b0;
        spi_copi <= tx_sh[FLEN-2];
        tx_sh    <= {tx_sh[FLEN-2:0], 1'b0};
      end
      if (finish) begin
        spi_cs <= 1'b1;
        busy   <= BUSY_HOLD;
        if (rw_q) rdat <= rx_sh;
      end
`ifdef SPI_CTRL_CS_GAP_EN
      if (gap_exit) busy <= 1'b0;
`endif
    end
  end

`ifdef SPI_CTRL_CS_GAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           gcnt <= '0;
    else if (state == GAP)  gcnt <= gcnt + 1'b1;
    else                    gcnt <= '0;
  end
`endif

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - scoreboard bench for spi_controller at DIV=4 and DIV=1
// Honours SPI_CTRL_CS_GAP_EN for the expected inter-frame chip-select gap.
module tb_spi_controller;
  import spi_pkg::*;

  localparam int NI = 2;
`ifdef SPI_CTRL_CS_GAP_EN
  localparam int   GAP_EXP  = CS_GAP_DEF;
  localparam logic BUSY_END = 1'b1;
`else
  localparam int   GAP_EXP  = 1;
  localparam logic BUSY_END = 1'b0;
`endif

  typedef struct {
    int                 inst;
    logic               rw;
    logic [ASZ_DEF-1:0] addr;
    logic [DSZ_DEF-1:0] wdat;
    logic [DSZ_DEF-1:0] rdat;
    int                 acc;
  } item_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start [NI];
  logic rw [NI];
  logic [ASZ_DEF-1:0] addr [NI];
  logic [DSZ_DEF-1:0] wdat [NI];
  logic busy [NI];
  logic done [NI];
  logic [DSZ_DEF-1:0] rdat [NI];
  logic sclk [NI];
  logic cs [NI];
  logic copi [NI];
  logic cipo [NI];

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  item_t sb[$];
  int exp_done [NI];
  int done_cnt [NI];
  int nr [NI];
  int lowc [NI];
  int gap_cnt [NI];
  int gap_last [NI];
  logic [FRAME_LEN-1:0] bits [NI];
  logic sclk_prev [NI];
  logic cs_prev [NI];
  logic prw [NI];
  logic [DSZ_DEF-1:0] prd [NI];
  logic [DSZ_DEF-1:0] last_rd [NI];
  logic [DSZ_DEF-1:0] pmem [NI][128];
  logic [DSZ_DEF-1:0] emem [NI][128];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int DIVG = (g == 0) ? 4 : 1;
    item_t it;

    spi_controller #(.DIV(DIVG)) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start[g]),
      .rw       (rw[g]),
      .addr     (addr[g]),
      .wdat     (wdat[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .rdat     (rdat[g]),
      .spi_clk  (sclk[g]),
      .spi_cs   (cs[g]),
      .spi_copi (copi[g]),
      .spi_cipo (cipo[g])
    );

    // pin monitor, peripheral register-bank model and scoreboard consumer
    initial begin
      cipo[g] = 1'b0; sclk_prev[g] = 1'b0; cs_prev[g] = 1'b1; prw[g] = 1'b0;
      nr[g] = 0; lowc[g] = 0; gap_cnt[g] = 0; gap_last[g] = 0; done_cnt[g] = 0;
      bits[g] = '0; prd[g] = '0;
      forever begin
        @(negedge clk);
        if (!cs[g] && cs_prev[g]) begin
          gap_last[g] = gap_cnt[g]; gap_cnt[g] = 0; nr[g] = 0; lowc[g] = 0;
          bits[g] = '0; cipo[g] = 1'b0; prw[g] = 1'b0;
        end
        if (cs[g]) gap_cnt[g]++;
        else       lowc[g]++;
        if (!cs[g] && sclk[g] && !sclk_prev[g]) begin
          bits[g] = {bits[g][FRAME_LEN-2:0], copi[g]};
          nr[g]++;
          if (nr[g] == RX_FIRST - 1) begin
            prw[g] = bits[g][ASZ_DEF];
            prd[g] = pmem[g][bits[g][ASZ_DEF-1:0]];
          end
          if (nr[g] == FRAME_LEN && !bits[g][FRAME_LEN-1])
            pmem[g][bits[g][FRAME_LEN-2:DSZ_DEF]] = bits[g][DSZ_DEF-1:0];
        end
        if (!cs[g] && !sclk[g] && sclk_prev[g] && prw[g] &&
            nr[g] >= RX_FIRST - 1 && nr[g] < FRAME_LEN)
          cipo[g] = prd[g][FRAME_LEN - 1 - nr[g]];
        if (done[g]) begin
          done_cnt[g]++;
          check("sb_nonempty", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            it = sb.pop_front();
            check("done_inst", g, it.inst);
            check("rdat", rdat[g], it.rdat);
            check("copi_frame", bits[g], {it.rw, it.addr, it.wdat});
            check("rise_cnt", nr[g], FRAME_LEN);
            check("cs_low_cycles", lowc[g], 81 * DIVG);
            check("done_latency", cyc - it.acc, 81 * DIVG);
            check("busy_at_done", busy[g], BUSY_END);
          end
        end
        sclk_prev[g] = sclk[g];
        cs_prev[g]   = cs[g];
      end
    end
  end

  // called at a negedge; returns #1 after the accept edge with the expectation queued
  task automatic send(input int g, input logic r, input logic [ASZ_DEF-1:0] a,
                      input logic [DSZ_DEF-1:0] d);
    item_t it;
    start[g] = 1'b1; rw[g] = r; addr[g] = a; wdat[g] = d;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
    it.inst = g; it.rw = r; it.addr = a; it.wdat = d; it.acc = cyc;
    if (r) last_rd[g] = emem[g][a];
    else   emem[g][a] = d;
    it.rdat = last_rd[g];
    sb.push_back(it);
    exp_done[g]++;
  endtask

  task automatic wait_done(input int g);
    for (int i = 0; i < 1000 && !done[g]; i++) @(negedge clk);
    check("done_seen", done[g], 1'b1);
  endtask

  task automatic wait_idle(input int g);
    for (int i = 0; i < 64 && busy[g]; i++) @(negedge clk);
    check("busy_drop", busy[g], 1'b0);
  endtask

  initial begin
    logic [DSZ_DEF-1:0] w;
    for (int k = 0; k < NI; k++) begin
      start[k] = 1'b0; rw[k] = 1'b0; addr[k] = '0; wdat[k] = '0;
      last_rd[k] = '0; exp_done[k] = 0;
      for (int i = 0; i < 128; i++) begin
        w = (i == 3) ? 32'hA5A5_1234 : (32'h1357_9BDF ^ (32'(i) * 32'h0101_0101));
        pmem[k][i] = w;
        emem[k][i] = w;
      end
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst_sclk", sclk[k], 1'b0);
      check("rst_cs", cs[k], 1'b1);
      check("rst_copi", copi[k], 1'b0);
      check("rst_busy", busy[k], 1'b0);
      check("rst_done", done[k], 1'b0);
      check("rst_rdat", rdat[k], '0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    send(0, 1'b0, 7'h15, 32'hDEAD_BEEF); wait_done(0);
    wait_idle(0); send(0, 1'b1, 7'h03, 32'h0BAD_F00D); wait_done(0);
    wait_idle(0); send(0, 1'b1, 7'h15, 32'h0); wait_done(0);

    wait_idle(0); send(0, 1'b0, 7'h40, 32'h1234_5678); wait_done(0);
    check("cs_gap_b2b", gap_last[0], GAP_EXP);
    wait_idle(0); send(0, 1'b1, 7'h40, 32'hFFFF_FFFF); wait_done(0);
    check("cs_gap_b2b", gap_last[0], GAP_EXP);

    wait_idle(0); send(0, 1'b1, 7'h03, 32'h0);
    repeat (50) @(negedge clk);
    start[0] = 1'b1; rw[0] = 1'b0; addr[0] = 7'h7F; wdat[0] = 32'h5555_AAAA;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);

    wait_idle(0);
    start[0] = 1'b1; rw[0] = 1'b0; addr[0] = 7'h22; wdat[0] = 32'hFACE_0FF0;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 400 && nr[0] < 20; i++) @(negedge clk);
    check("abort_edge", nr[0], 20);
    reset_n = 1'b0;
    #1;
    check("abort_cs", cs[0], 1'b1);
    check("abort_sclk", sclk[0], 1'b0);
    check("abort_busy", busy[0], 1'b0);
    check("abort_done", done[0], 1'b0);
    check("abort_rdat", rdat[0], '0);
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(0, 1'b1, 7'h22, 32'h0); wait_done(0);

    wait_idle(1); send(1, 1'b0, 7'h15, 32'hCAFE_F00D); wait_done(1);
    wait_idle(1); send(1, 1'b1, 7'h03, 32'h0); wait_done(1);
    wait_idle(1); send(1, 1'b1, 7'h15, 32'h0); wait_done(1);
    check("cs_gap_b2b_div1", gap_last[1], GAP_EXP);

    repeat (400) @(negedge clk);
    for (int k = 0; k < NI; k++) check("done_count", done_cnt[k], exp_done[k]);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
